vec_mem_sequencer: RTL and testbench
====================================

// Module: vec_mem_sequencer
// PURPOSE
//  Sequences scalar and vector memory ops in the MEM stage over a single N-bit data-memory port.
//  Scalar ops pass through in one cycle. Vector ops are serialised into V element accesses while
//    the pipeline is stalled. Loaded elements are assembled into a V x N buffer.
//  Drives the enable of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and feeds Data_Mem_S/V into MEM/WB.
// PARAMETERS
//  N  32  element / scalar data width and address width (word-addressed memory)
//  V  20  elements per vector (V >= 1)
// PORTS
//  CLK             in   1      clock, rising edge
//  RST             in   1      synchronous, active-high reset
//  start_i         in   1      MEM-stage instruction is a memory op (valid)
//  vector_i        in   1      1 = vector op, 0 = scalar op
//  write_i         in   1      1 = store, 0 = load
//  addr_i          in   N      base word address
//  wdata_s_i       in   N      scalar store data
//  wdata_v_i       in   V*N    vector store data ([V-1:0][N-1:0], element 0 at base)
//  mem_rdata_i     in   N      memory read data (combinational/asynchronous read of mem_addr_o)
//  mem_addr_o      out  N      memory address
//  mem_we_o        out  1      memory write enable
//  mem_wdata_o     out  N      memory write data
//  data_mem_s_o    out  N      scalar load data to MEM/WB
//  data_mem_v_o    out  V*N    vector load buffer to MEM/WB
//  stall_o         out  1      1 = hold pipeline
//  pipe_enable_o   out  1      ~stall_o, tied to all pipe-register enables
//  done_o          out  1      one-cycle pulse: vector op complete
// BEHAVIOUR
//  FSM states: IDLE, XFER, DONE. Element counter idx is $clog2(V) bits wide, minimum 1 bit.
//  IDLE, scalar (start_i=1, vector_i=0):
//    mem_addr_o=addr_i, mem_we_o=write_i, mem_wdata_o=wdata_s_i, data_mem_s_o=mem_rdata_i.
//    All of these are combinational. stall_o=0. Stay in IDLE.
//  IDLE, vector (start_i=1, vector_i=1):
//    stall_o=1 combinationally; mem_we_o=0.
//    Latch base<=addr_i, wbuf<=wdata_v_i and wr<=write_i. Set idx<=0 and go to XFER.
//  IDLE, no start: mem_we_o=0, mem_addr_o=addr_i, stall_o=0.
//  XFER:
//    stall_o=1, mem_addr_o=base+idx (mod 2^N, wraps silently), mem_we_o=wr, mem_wdata_o=wbuf[idx].
//    On a load, at the edge: data_mem_v_o[idx]<=mem_rdata_i. A store leaves data_mem_v_o unchanged.
//    If idx==V-1, go to DONE. Otherwise idx<=idx+1.
//  DONE:
//    stall_o=0, done_o=1, mem_we_o=0. Pipe registers capture data_mem_v_o at this edge. Go to IDLE.
//    start_i is ignored in DONE: it still reflects the completed instruction.
//  Latency: vector op stalls V+1 cycles (1 IDLE + V XFER). It advances on the DONE edge, V+2 cycles after start.
//  Scalar op latency: 0 extra cycles.
//  data_mem_v_o holds its value between ops. Inputs are don't-care in XFER (latched copies are used).
//  Reset (any state, including mid-XFER):
//    state=IDLE, idx=0, base=0, wbuf=0, wr=0, data_mem_v_o=0.
//    Outputs in the reset cycle: stall_o=0, done_o=0, mem_we_o=0.
//    No partial write continues after reset.
//  V=1: exactly one XFER cycle, then DONE.
// TESTING
//  Scalar load, addr 0x10, mem[0x10]=0xDEAD -> data_mem_s_o=0xDEAD same cycle; stall_o never 1.
//  Vector load, base 0x100, mem[a]=3*a -> stall_o=1 for 21 cycles, done_o on the 22nd.
//    Expect data_mem_v_o[i]=3*(0x100+i), i=0..19.
//  Vector store, base 0x200, wdata_v_i[i]=i+1 -> mem_we_o=1 for 20 cycles at 0x200..0x213, mem[0x213]=20.
//    data_mem_v_o unchanged.
//  Back-to-back vector load, then scalar store held on start_i -> second op not re-issued in DONE.
//    Scalar store seen in the IDLE cycle after DONE.
//  RST asserted at idx=7 of a vector store -> next cycle IDLE, stall_o=0, data_mem_v_o=0.
//    mem_we_o=0 from the reset cycle on.
//  Vector load, base 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0 ... 0x11 (wrap, no error).

Source files
------------

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer for scalar and vector memory ops over one N-bit memory port.
// Scalar ops pass straight through in the same cycle. A vector op stalls the
// pipeline while its V elements are accessed one per cycle. Loaded elements are
// assembled into data_mem_v_o.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pass scalar ops through; on a vector op latch it and stall
// XFER  | one element access per cycle at base+idx, pipeline stalled
// DONE  | release stall, pulse done_o, MEM/WB captures the vector buffer
module vec_mem_sequencer #(
   parameter int N = 32,
   parameter int V = 20
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start_i,
   input  logic                  vector_i,
   input  logic                  write_i,
   input  logic [N-1:0]          addr_i,
   input  logic [N-1:0]          wdata_s_i,
   input  logic [V-1:0][N-1:0]   wdata_v_i,
   input  logic [N-1:0]          mem_rdata_i,
   output logic [N-1:0]          mem_addr_o,
   output logic                  mem_we_o,
   output logic [N-1:0]          mem_wdata_o,
   output logic [N-1:0]          data_mem_s_o,
   output logic [V-1:0][N-1:0]   data_mem_v_o,
   output logic                  stall_o,
   output logic                  pipe_enable_o,
   output logic                  done_o
);

   localparam int IW = (V > 1) ? $clog2(V) : 1;
   localparam logic [IW-1:0] LAST = IW'(V - 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t                state, state_nxt;
   logic [IW-1:0]         idx;
   logic [N-1:0]          base;
   logic [V-1:0][N-1:0]   wbuf;
   logic                  wr;
   logic                  vec_go;

   assign vec_go = (state == IDLE) && start_i && vector_i;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Latch the vector op on entry, then step idx and collect load data in XFER.
   always_ff @(posedge CLK) begin
      if (RST) begin
         idx          <= '0;
         base         <= '0;
         wbuf         <= '0;
         wr           <= 1'b0;
         data_mem_v_o <= '0;
      end else if (vec_go) begin
         base <= addr_i;
         wbuf <= wdata_v_i;
         wr   <= write_i;
         idx  <= '0;
      end else if (state == XFER) begin
         if (!wr) data_mem_v_o[idx] <= mem_rdata_i;
         if (idx != LAST) idx <= idx + 1'b1;
      end
   end

   // Next state and memory-port / pipeline-control outputs.
   always_comb begin
      state_nxt   = state;
      mem_addr_o  = addr_i;
      mem_we_o    = 1'b0;
      mem_wdata_o = wdata_s_i;
      stall_o     = 1'b0;
      done_o      = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               if (vector_i) begin
                  stall_o   = 1'b1;
                  state_nxt = XFER;
               end else begin
                  mem_we_o = write_i;
               end
            end
         end
         XFER: begin
            stall_o     = 1'b1;
            mem_addr_o  = base + N'(idx);
            mem_we_o    = wr;
            mem_wdata_o = wbuf[idx];
            if (idx == LAST) state_nxt = DONE;
         end
         DONE: begin
            // start_i still shows the finished instruction here, so it is not looked at.
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Kill any in-flight write and release the pipeline during the reset cycle itself.
      if (RST) begin
         stall_o  = 1'b0;
         done_o   = 1'b0;
         mem_we_o = 1'b0;
      end
   end

   assign pipe_enable_o = ~stall_o;
   assign data_mem_s_o  = mem_rdata_i;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Bench for vec_mem_sequencer: scalar vector table plus hand-built vector sequences.
// Expected writes and expected load elements go through scoreboard queues.
module tb_vec_mem_sequencer;
   localparam int N = 32;
   localparam int V = 20;

   logic                CLK = 1'b0;
   logic                RST;
   logic                start_i, vector_i, write_i;
   logic [N-1:0]        addr_i, wdata_s_i, mem_rdata_i;
   logic [V-1:0][N-1:0] wdata_v_i;
   logic [N-1:0]        mem_addr_o, mem_wdata_o, data_mem_s_o;
   logic                mem_we_o, stall_o, pipe_enable_o, done_o;
   logic [V-1:0][N-1:0] data_mem_v_o;

   int n_tests = 0;
   int n_fail  = 0;

   vec_mem_sequencer #(.N(N), .V(V)) dut (
      .CLK(CLK), .RST(RST), .start_i(start_i), .vector_i(vector_i), .write_i(write_i),
      .addr_i(addr_i), .wdata_s_i(wdata_s_i), .wdata_v_i(wdata_v_i), .mem_rdata_i(mem_rdata_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
      .data_mem_s_o(data_mem_s_o), .data_mem_v_o(data_mem_v_o), .stall_o(stall_o),
      .pipe_enable_o(pipe_enable_o), .done_o(done_o)
   );

   always #5 CLK = ~CLK;

   // Memory model: written words override a default image of 3*addr, with 0x10 = 0xDEAD.
   logic [N-1:0] mem [0:4095];
   bit           wrt [0:4095];

   function automatic logic [N-1:0] mem_model(input logic [N-1:0] a);
      if (wrt[a[11:0]]) return mem[a[11:0]];
      if (a == 32'h10) return 32'hDEAD;
      return a * 32'd3;
   endfunction

   assign mem_rdata_i = wrt[mem_addr_o[11:0]] ? mem[mem_addr_o[11:0]] :
                        (mem_addr_o == 32'h10) ? 32'hDEAD : mem_addr_o * 32'd3;

   always @(posedge CLK) begin
      if (mem_we_o) begin
         mem[mem_addr_o[11:0]] <= mem_wdata_o;
         wrt[mem_addr_o[11:0]] <= 1'b1;
      end
   end

   typedef struct packed {
      logic [N-1:0] addr;
      logic [N-1:0] data;
   } wr_t;

   wr_t          wq[$];
   logic [N-1:0] vq[$];
   logic [N-1:0] exp_vbuf [V];

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Every memory write must match the oldest expected write.
   always @(negedge CLK) begin
      if (mem_we_o) begin
         if (wq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr_o, mem_wdata_o);
         end else begin
            wr_t w;
            w = wq.pop_front();
            chk("wr_addr", mem_addr_o, w.addr);
            chk("wr_data", mem_wdata_o, w.data);
         end
      end
   end

   task automatic cmp_vbuf(input string name);
      for (int i = 0; i < V; i++) chk(name, data_mem_v_o[i], exp_vbuf[i]);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_chk();
      start_i  = 1'b0;
      vector_i = 1'b0;
      write_i  = 1'b0;
      @(negedge CLK);
      chk1("idle_stall", stall_o, 1'b0);
      chk1("idle_we", mem_we_o, 1'b0);
      step();
   endtask

   // Issue one vector op; from the first XFER cycle on, drive the h_* inputs instead.
   task automatic vec_op(input logic [N-1:0] base, input logic wr, input logic [V-1:0][N-1:0] wv,
                         input logic h_start, input logic h_vec, input logic h_wr,
                         input logic [N-1:0] h_addr, input logic [N-1:0] h_ws);
      bit seen;
      start_i   = 1'b1;
      vector_i  = 1'b1;
      write_i   = wr;
      addr_i    = base;
      wdata_v_i = wv;
      for (int i = 0; i < V; i++) begin
         if (wr) wq.push_back(wr_t'{base + N'(i), wv[i]});
         else    vq.push_back(mem_model(base + N'(i)));
      end
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge CLK);
         chk1("vec_stall", stall_o, c <= V);
         chk1("vec_pipe_en", pipe_enable_o, c > V);
         chk1("vec_done", done_o, c == V + 1);
         if (c >= 1 && c <= V) chk("xfer_addr", mem_addr_o, base + N'(c - 1));
         if (done_o) begin
            seen = 1'b1;
            chk1("done_we", mem_we_o, 1'b0);
         end
         step();
         if (c == 0) begin
            start_i   = h_start;
            vector_i  = h_vec;
            write_i   = h_wr;
            addr_i    = h_addr;
            wdata_s_i = h_ws;
            for (int i = 0; i < V; i++) wdata_v_i[i] = $urandom;
         end
      end
      chk1("done_seen", seen, 1'b1);
      if (!wr) for (int i = 0; i < V; i++) exp_vbuf[i] = (vq.size() > 0) ? vq.pop_front() : '0;
      cmp_vbuf("vbuf");
   endtask

   typedef struct {
      logic         start, vec, wr;
      logic [N-1:0] addr, ws;
      logic         exp_we, exp_stall;
      logic [N-1:0] exp_addr, exp_rd;
   } vec_t;

   vec_t                tbl [6];
   logic [V-1:0][N-1:0] tv;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 1'b0, 32'h10,  32'hDEAD};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h40,  32'hC0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h300, 32'h12345678, 1'b1, 1'b0, 32'h300, 32'h900};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h300, 32'h0,        1'b0, 1'b0, 32'h300, 32'h12345678};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h55,  32'hFFFF,     1'b0, 1'b0, 32'h55,  32'hFF};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h60,  32'h0,        1'b0, 1'b0, 32'h60,  32'h120};

      RST = 1'b1; start_i = 1'b0; vector_i = 1'b0; write_i = 1'b0;
      addr_i = '0; wdata_s_i = '0; wdata_v_i = '0;
      for (int i = 0; i < V; i++) exp_vbuf[i] = '0;
      step();
      @(negedge CLK);
      chk1("rst_stall", stall_o, 1'b0);
      chk1("rst_done", done_o, 1'b0);
      chk1("rst_we", mem_we_o, 1'b0);
      cmp_vbuf("rst_vbuf");
      step();
      RST = 1'b0;

      // Scalar pass-through table.
      for (int k = 0; k < 6; k++) begin
         start_i = tbl[k].start; vector_i = tbl[k].vec; write_i = tbl[k].wr;
         addr_i = tbl[k].addr; wdata_s_i = tbl[k].ws;
         if (tbl[k].exp_we) wq.push_back(wr_t'{tbl[k].addr, tbl[k].ws});
         @(negedge CLK);
         chk1("scl_we", mem_we_o, tbl[k].exp_we);
         chk1("scl_stall", stall_o, tbl[k].exp_stall);
         chk1("scl_pipe_en", pipe_enable_o, ~tbl[k].exp_stall);
         chk1("scl_done", done_o, 1'b0);
         chk("scl_addr", mem_addr_o, tbl[k].exp_addr);
         chk("scl_rdata", data_mem_s_o, tbl[k].exp_rd);
         step();
      end

      // Vector load at 0x100; inputs change to junk during XFER.
      vec_op(32'h100, 1'b0, '0, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
      idle_chk();

      // Vector store at 0x200 with element i = i+1; load buffer must not change.
      for (int i = 0; i < V; i++) tv[i] = N'(i + 1);
      vec_op(32'h200, 1'b1, tv, 1'b1, 1'b1, 1'b0, $urandom, $urandom);
      idle_chk();
      start_i = 1'b1; vector_i = 1'b0; write_i = 1'b0; addr_i = 32'h213;
      @(negedge CLK);
      chk("store_readback", data_mem_s_o, 32'd20);
      step();

      // Vector load followed by a scalar store already waiting on the inputs.
      vec_op(32'h180, 1'b0, '0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D);
      wq.push_back(wr_t'{32'h400, 32'hCAFEF00D});
      @(negedge CLK);
      chk1("b2b_stall", stall_o, 1'b0);
      chk1("b2b_we", mem_we_o, 1'b1);
      step();
      idle_chk();

      // Address wrap past 0xFFFFFFFF.
      vec_op(32'hFFFFFFFE, 1'b0, '0, 1'b1, 1'b1, 1'b0, $urandom, $urandom);
      idle_chk();

      // Reset in the middle of a vector store at idx 7.
      for (int i = 0; i < V; i++) tv[i] = 32'hA0 + N'(i);
      for (int i = 0; i < 7; i++) wq.push_back(wr_t'{32'h500 + N'(i), tv[i]});
      start_i = 1'b1; vector_i = 1'b1; write_i = 1'b1; addr_i = 32'h500; wdata_v_i = tv;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 7; i++) step();
      RST = 1'b1;
      @(negedge CLK);
      chk1("mid_rst_we", mem_we_o, 1'b0);
      chk1("mid_rst_stall", stall_o, 1'b0);
      chk1("mid_rst_done", done_o, 1'b0);
      step();
      RST = 1'b0;
      for (int i = 0; i < V; i++) exp_vbuf[i] = '0;
      @(negedge CLK);
      chk1("post_rst_stall", stall_o, 1'b0);
      chk1("post_rst_we", mem_we_o, 1'b0);
      chk1("post_rst_done", done_o, 1'b0);
      cmp_vbuf("post_rst_vbuf");
      step();
      idle_chk();

      chk("wq_empty", N'(wq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
